binary_serial_subtractor: RTL and testbench
===========================================

# binary_serial_subtractor

Bit-serial unsigned/two's-complement subtractor that computes `diff = a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the team's binary serial adder and shares its operand/shift-register structure. Unlike the adder, it has an explicit start/busy/done handshake, so a controller can issue back-to-back operations without fixed-delay assumptions. It sits between operand registers and the datapath result bus.

## Interface
- `N`, default 16: operand and result width in bits; legal range N ≥ 2.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: asynchronous, active-low reset.
- `start`  input  1: request an operation; sampled only in IDLE.
- `a`  input  N: minuend; captured on the accepting edge.
- `b`  input  N: subtrahend; captured on the accepting edge.
- `bin`  input  1: borrow-in; captured on the accepting edge.
- `busy`  output  1: high from the accepting edge until the result is presented.
- `done`  output  1: single-cycle pulse; the result is valid.
- `diff`  output  N: registered difference; holds its value until the next completion.
- `bout`  output  1: borrow-out; 1 when a < b + bin (unsigned).
- `ovf`  output  1: signed overflow of a − b − bin.

## Operation
- States: IDLE, SHIFT, DONE. Counter width is $clog2(N).
- IDLE:
  - When `start`=1, load `a` into shift register A, `b` into shift register B, `bin` into the borrow FF.
  - Clear the counter and the diff shift register, latch a[N-1] and b[N-1] for overflow, then go to SHIFT.
- SHIFT, per edge:
  - d = A[0] ^ B[0] ^ br.
  - br' = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br).
  - A and B shift right by one; d enters the diff shift register at the MSB with a right shift.
  - The counter increments.
  - On the edge that processes bit N-1 (counter = N-1), go to DONE. That same edge loads outputs `diff`, `bout` = br', and `ovf` = (a[N-1] ^ b[N-1]) & (d ^ a[N-1]).
- DONE: `done`=1 for this one cycle. The next edge returns to IDLE.
- `start` in SHIFT or DONE is ignored and not queued.
- `start` held high in IDLE after DONE begins a new operation on the first IDLE edge. Back-to-back throughput is one result per N+2 cycles.
- Operand inputs are don't-care except on the accepting edge.
- Reset (asynchronous, any state):
  - State goes to IDLE; all registers clear.
  - `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0.
  - An operation in flight is discarded with no done pulse.
- Releasing reset while `start`=1 is legal. The first rising edge with rst=1 accepts it.

## Timing
- Edge 0 is the edge that samples `start`=1 in IDLE.
- `busy`:
  - Registered.
  - Goes high after edge 0.
  - Stays high through the SHIFT cycles.
  - Goes low after edge N, i.e. busy=0 while done=1.
- Edges 1..N process bits 0..N-1.
- `done`, `diff`, `bout` and `ovf` update after edge N. `done` falls after edge N+1.
- Start-to-done latency is N cycles after the accepting edge; done is visible in cycle N+1 counting edge 0 as cycle 1.
- Earliest next accept is edge N+2.
- All outputs are registered. There is no combinational input-to-output path.

## Test plan
- Reset → all outputs 0. Then a=209, b=108, bin=0 → after 16 cycles, done pulses for 1 cycle with diff=101, bout=0, ovf=0.
- a=101, b=108, bin=0 → diff=0xFFF9, bout=1, ovf=0. Then a=1000, b=1, bin=1 → diff=998, bout=0.
- a=0, b=0, bin=1 → diff=0xFFFF, bout=1, ovf=0. Also a=0x8000, b=1, bin=0 → diff=0x7FFF, bout=0, ovf=1.
- start pulsed again at cycles 3 and 10 of an operation with different operands → ignored; the first result is unchanged and exactly one done pulse occurs.
- rst asserted mid-SHIFT (cycle 7) → outputs 0 immediately with no done. After release, a=255, b=255 → diff=0, bout=0.
- start held high continuously for four operations → done pulses are spaced 18 cycles apart, and the results match a reference model of a − b − bin for randomised a, b, bin.

Source files
------------

// File: rtl/binary_serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start handshake in, busy/done and result out.
interface binary_serial_subtractor_if #(
    parameter int N = 16
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/binary_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor cell plus a borrow flop.
module binary_serial_subtractor #(
    parameter int N = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    binary_serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic fs_diff(input logic x, input logic y, input logic br);
        return x ^ y ^ br;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic br);
        return (~x & y) | (~(x ^ y) & br);
    endfunction

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic           r_br;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_dsh;
    logic           r_a_msb;
    logic           r_b_msb;
    logic [N-1:0]   r_diff;
    logic           r_bout;
    logic           r_ovf;
    logic           r_busy;
    logic           r_done;
    logic           w_busy_nxt;
    logic           w_done_nxt;
    logic           w_last;
    logic           w_d;
    logic           w_br_nxt;

    assign w_d      = fs_diff(r_a[0], r_b[0], r_br);
    assign w_br_nxt = fs_borrow(r_a[0], r_b[0], r_br);
    assign w_last   = (r_cnt == CW'(N - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start outside IDLE is simply not looked at
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_SHIFT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SHIFT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the upcoming state and then registered
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_next)
            S_SHIFT: w_busy_nxt = 1'b1;
            S_DONE:  w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Operand shift registers, borrow flop, bit counter and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= {N{1'b0}};
            r_b     <= {N{1'b0}};
            r_br    <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_dsh   <= {N{1'b0}};
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_diff  <= {N{1'b0}};
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_br    <= bus.bin;
                        r_cnt   <= {CW{1'b0}};
                        r_dsh   <= {N{1'b0}};
                        r_a_msb <= bus.a[N-1];
                        r_b_msb <= bus.b[N-1];
                    end
                end
                S_SHIFT: begin
                    r_a   <= {1'b0, r_a[N-1:1]};
                    r_b   <= {1'b0, r_b[N-1:1]};
                    r_br  <= w_br_nxt;
                    r_dsh <= {w_d, r_dsh[N-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    // w_d is the result MSB on the last bit, so it feeds the overflow test directly
                    if (w_last) begin
                        r_diff <= {w_d, r_dsh[N-1:1]};
                        r_bout <= w_br_nxt;
                        r_ovf  <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_binary_serial_subtractor.sv
// Directed plus randomized bench for binary_serial_subtractor against an integer reference model.
module tb_binary_serial_subtractor;
    localparam int N = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc_cnt;

    binary_serial_subtractor_if #(.N(N)) bus ();

    binary_serial_subtractor #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                         output logic [N-1:0] d, output logic bo, output logic ov);
        longint ua, ub, ubin, sa, sb, r, rs, m;
        m    = longint'(1) << N;
        ua   = longint'(a);
        ub   = longint'(b);
        ubin = longint'(bin);
        r    = ua - ub - ubin;
        d    = N'(r);
        bo   = (ua < ub + ubin);
        sa   = a[N-1] ? ua - m : ua;
        sb   = b[N-1] ? ub - m : ub;
        rs   = sa - sb - ubin;
        ov   = (rs < -(m / 2)) || (rs > (m / 2) - 1);
    endtask

    task automatic wait_done(output int cyc);
        bit found;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done) found = 1'b1;
        end
    endtask

    task automatic check_result(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic bin);
        logic [N-1:0] ed;
        logic         eb, eo;
        model(a, b, bin, ed, eb, eo);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        check({tag, "_bout"}, 32'(bus.bout), 32'(eb));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    endtask

    // One operation; with inject set, stray start pulses with new operands hit cycles 3 and 10
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic bin, input bit inject);
        int cyc;
        bit found;
        logic [N-1:0] held;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
        bus.bin   = 1'($urandom);
        check({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (inject && (cyc == 3 || cyc == 10)) begin
                bus.start = 1'b1;
                bus.a     = N'($urandom);
                bus.b     = N'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) found = 1'b1;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(N));
        check_result(tag, a, b, bin);
        held = bus.diff;
        @(posedge clk); #1;
        check({tag, "_done_falls"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
        check({tag, "_diff_held"}, 32'(bus.diff), 32'(held));
    endtask

    initial begin
        logic [N-1:0] ea, eb;
        logic         ebin;
        int           cyc;
        int           last_done;

        n_checks  = 0;
        n_errors  = 0;
        cyc_cnt   = 0;
        last_done = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        check("rst_ovf",  32'(bus.ovf),  32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("op_209_108", 16'd209, 16'd108, 1'b0, 1'b0);
        run_op("op_101_108", 16'd101, 16'd108, 1'b0, 1'b0);
        run_op("op_1000_1_b", 16'd1000, 16'd1, 1'b1, 1'b0);
        run_op("op_0_0_b", 16'd0, 16'd0, 1'b1, 1'b0);
        run_op("op_8000_1", 16'h8000, 16'd1, 1'b0, 1'b0);
        check("lit_8000_diff", 32'(bus.diff), 32'h7FFF);
        check("lit_8000_ovf", 32'(bus.ovf), 32'd1);
        run_op("op_inject", 16'd5000, 16'd1234, 1'b0, 1'b1);
        check("lit_inject_diff", 32'(bus.diff), 32'd3766);

        // Reset in the middle of SHIFT discards the operation
        bus.a     = 16'd40000;
        bus.b     = 16'd3;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_diff", 32'(bus.diff), 32'd0);
        check("midrst_bout", 32'(bus.bout), 32'd0);
        check("midrst_ovf",  32'(bus.ovf),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_done(cyc);
        check("midrst_no_done", 32'(cyc), 32'd40);
        run_op("op_255_255", 16'd255, 16'd255, 1'b0, 1'b0);

        // start held high: four randomized back-to-back operations
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
        bus.bin   = 1'($urandom);
        bus.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("b2b_busy_after_accept", 32'(bus.busy), 32'd1);
            ea      = bus.a;
            eb      = bus.b;
            ebin    = bus.bin;
            bus.a   = N'($urandom);
            bus.b   = N'($urandom);
            bus.bin = 1'($urandom);
            wait_done(cyc);
            check("b2b_latency", 32'(cyc), 32'(N));
            check_result("b2b", ea, eb, ebin);
            if (k > 0) begin
                check("b2b_spacing", 32'(cyc_cnt - last_done), 32'(N + 2));
            end
            last_done = cyc_cnt;
            @(posedge clk); #1;
            check("b2b_done_falls", 32'(bus.done), 32'd0);
            if (k == 3) bus.start = 1'b0;
        end
        @(posedge clk); #1;
        check("final_idle_busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
